// File: rtl/irq_ack_controller.sv
// CPU-side interrupt acknowledge controller: sticky pending capture, lowest-id-first
// request/vector presentation, ack/EOI handshake. Optional merged-event counter: IRQ_MISS_CNT_EN.
module irq_ack_controller #(
    parameter int          NUM_SRC    = 4,
    parameter int          ID_W       = 2,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               irq_in,
    input  logic [ID_W-1:0]    irq_id,
    input  logic               int_en,
    output logic               int_req,
    output logic [31:0]        int_vec,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [NUM_SRC-1:0] src_clr,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy,
    output logic [7:0]         miss_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

    state_t             state_r, state_nxt_s;
    logic               irq_q_r;
    logic [NUM_SRC-1:0] pending_r, pending_nxt_s;
    logic [NUM_SRC-1:0] src_clr_r, src_clr_nxt_s;
    logic [NUM_SRC-1:0] set_mask_s, clr_mask_s;
    logic [ID_W-1:0]    cur_id_r, cur_id_nxt_s, lowest_id_s;
    logic               int_req_r, int_req_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [31:0]        int_vec_r, int_vec_nxt_s;
    logic               edge_s, ack_s, merge_s;

    assign edge_s = irq_in & ~irq_q_r;
    assign ack_s  = (state_r == REQ) & int_ack;

    // An id beyond the vector width shifts out to zero, which drops out-of-range ids.
    assign set_mask_s    = edge_s ? (ONE_HOT0 << irq_id) : {NUM_SRC{1'b0}};
    assign clr_mask_s    = ack_s ? (ONE_HOT0 << cur_id_r) : {NUM_SRC{1'b0}};
    assign pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
    assign merge_s       = |(set_mask_s & pending_r & ~clr_mask_s);

    // Priority pick: scanning downward leaves the lowest set index.
    always_comb begin
        lowest_id_s = {ID_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            lowest_id_s = pending_r[i] ? ID_W'(i) : lowest_id_s;
        end
    end

    // Next-state and next-output logic for the request/service handshake.
    always_comb begin
        state_nxt_s   = state_r;
        cur_id_nxt_s  = cur_id_r;
        int_req_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        int_vec_nxt_s = int_vec_r;
        src_clr_nxt_s = {NUM_SRC{1'b0}};
        case (state_r)
            IDLE: begin
                if (int_en && (|pending_r)) begin
                    state_nxt_s   = REQ;
                    cur_id_nxt_s  = lowest_id_s;
                    int_req_nxt_s = 1'b1;
                    int_vec_nxt_s = VEC_BASE + (32'(lowest_id_s) * 32'(VEC_STRIDE));
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_nxt_s   = SERVICE;
                    busy_nxt_s    = 1'b1;
                    src_clr_nxt_s = clr_mask_s;
                end else begin
                    state_nxt_s   = REQ;
                    int_req_nxt_s = 1'b1;
                end
            end
            SERVICE: begin
                if (int_eoi) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            irq_q_r   <= 1'b0;
            pending_r <= {NUM_SRC{1'b0}};
            src_clr_r <= {NUM_SRC{1'b0}};
            cur_id_r  <= {ID_W{1'b0}};
            int_req_r <= 1'b0;
            busy_r    <= 1'b0;
            int_vec_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            irq_q_r   <= irq_in;
            pending_r <= pending_nxt_s;
            src_clr_r <= src_clr_nxt_s;
            cur_id_r  <= cur_id_nxt_s;
            int_req_r <= int_req_nxt_s;
            busy_r    <= busy_nxt_s;
            int_vec_r <= int_vec_nxt_s;
        end
    end

`ifdef IRQ_MISS_CNT_EN
    logic [7:0] miss_cnt_r;

    // Saturating count of edges merged into an already-pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_r <= 8'h00;
        end else if (merge_s && (miss_cnt_r != 8'hFF)) begin
            miss_cnt_r <= miss_cnt_r + 8'h01;
        end else begin
            miss_cnt_r <= miss_cnt_r;
        end
    end

    assign miss_cnt = miss_cnt_r;
`else
    logic unused_merge_s;
    assign unused_merge_s = merge_s;
    assign miss_cnt       = 8'h00;
`endif

    assign int_req = int_req_r;
    assign int_vec = int_vec_r;
    assign src_clr = src_clr_r;
    assign pending = pending_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_irq_ack_controller.sv
// Scoreboard bench for irq_ack_controller: directed scenarios then random traffic,
// checked against a transaction-level reference model.
module tb_irq_ack_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq_in = 1'b0;
    logic [1:0]  irq_id = 2'd0;
    logic        int_en = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_eoi = 1'b0;
    logic        int_req;
    logic [31:0] int_vec;
    logic [3:0]  src_clr;
    logic [3:0]  pending;
    logic        busy;
    logic [7:0]  miss_cnt;

    irq_ack_controller dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_id(irq_id), .int_en(int_en),
        .int_req(int_req), .int_vec(int_vec), .int_ack(int_ack), .int_eoi(int_eoi),
        .src_clr(src_clr), .pending(pending), .busy(busy), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state (phase: 0 waiting, 1 requesting, 2 in handler)
    logic [3:0]  m_pend = 4'd0;
    int          m_phase = 0;
    int          m_cur = 0;
    bit          m_prev = 1'b0;
    int          m_miss = 0;
    logic [31:0] m_vec = 32'd0;
    logic [3:0]  e_clr = 4'd0;
    logic [31:0] req_q[$];
    logic [3:0]  clr_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending is a set, the controller serves the smallest member when enabled.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_pend = 4'd0; m_phase = 0; m_prev = 1'b0; m_miss = 0; m_vec = 32'd0; e_clr = 4'd0;
        end else begin
            bit          ev;
            logic [3:0]  setm, clrm;
            ev   = irq_in && !m_prev;
            m_prev = irq_in;
            setm = ev ? (4'b0001 << irq_id) : 4'b0000;
            clrm = (m_phase == 1 && int_ack) ? (4'b0001 << m_cur) : 4'b0000;
            if ((setm & m_pend & ~clrm) != 4'd0 && m_miss < 255) m_miss++;
            e_clr = clrm;
            if (m_phase == 0) begin
                if (int_en && m_pend != 4'd0) begin
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) m_cur = i;
                    m_vec = 32'h100 + 32'(4 * m_cur);
                    m_phase = 1;
                    req_q.push_back(m_vec);
                end
            end else if (m_phase == 1) begin
                if (int_ack) begin
                    m_phase = 2;
                    clr_q.push_back(clrm);
                end
            end else begin
                if (int_eoi) m_phase = 0;
            end
            m_pend = (m_pend & ~clrm) | setm;
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pops on request rise and clear pulse.
    initial begin
        bit seen_req;
        seen_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("int_req", {31'd0, int_req}, {31'd0, m_phase == 1});
                chk("busy", {31'd0, busy}, {31'd0, m_phase == 2});
                chk("pending", {28'd0, pending}, {28'd0, m_pend});
                chk("int_vec", int_vec, m_vec);
                chk("src_clr", {28'd0, src_clr}, {28'd0, e_clr});
`ifdef IRQ_MISS_CNT_EN
                chk("miss_cnt", {24'd0, miss_cnt}, 32'(m_miss));
`else
                chk("miss_cnt", {24'd0, miss_cnt}, 32'd0);
`endif
                if (src_clr != 4'd0) begin
                    if (clr_q.size() == 0) chk("src_clr_unexpected", {28'd0, src_clr}, 32'd0);
                    else chk("src_clr_sb", {28'd0, src_clr}, {28'd0, clr_q.pop_front()});
                end
                if (int_req && !seen_req) begin
                    if (req_q.size() == 0) chk("req_unexpected", int_vec, 32'hFFFF_FFFF);
                    else chk("int_vec_sb", int_vec, req_q.pop_front());
                end
                seen_req = int_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        irq_in = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [1:0] id);
        irq_in = 1'b1; irq_id = id;
        tick();
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (m_phase != ph && k < 30) begin tick(); k++; end
        if (m_phase != ph) begin
            n_err++;
            $display("FAIL wait_phase: phase %0d expected %0d", m_phase, ph);
        end
    endtask

    task automatic service();
        wait_phase(1);
        idle(1);
        int_ack = 1'b1; tick();
        idle(1);
        int_eoi = 1'b1; tick();
    endtask

    initial begin
        idle(2);
        mon_en = 1'b1;
        idle(1);
        rst = 1'b0;
        // Single event, id 2
        int_en = 1'b1;
        idle(2);
        pulse(2'd2);
        service();
        idle(2);
        // Priority ordering with interrupts disabled
        int_en = 1'b0;
        pulse(2'd3); idle(1); pulse(2'd1); idle(2);
        int_en = 1'b1;
        service(); service();
        idle(2);
        // No preemption
        pulse(2'd2); idle(2);
        pulse(2'd0); idle(2);
        service(); service();
        idle(2);
        // Collision of set and clear on id 1
        pulse(2'd1);
        wait_phase(1);
        irq_in = 1'b1; irq_id = 2'd1; int_ack = 1'b1; tick();
        idle(1);
        int_eoi = 1'b1; tick();
        service();
        idle(2);
        // Merge and counter
        int_en = 1'b0;
        pulse(2'd3); idle(1); pulse(2'd3); idle(1); pulse(2'd3); idle(1);
        int_en = 1'b1;
        service();
        idle(3);
        // Held-high input yields a single event
        for (int i = 0; i < 4; i++) begin irq_in = 1'b1; irq_id = 2'd2; tick(); end
        service();
        idle(2);
        // Reset in service, then a stray eoi and ack
        pulse(2'd1);
        wait_phase(1);
        int_ack = 1'b1; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        int_eoi = 1'b1; tick();
        int_ack = 1'b1; tick();
        idle(2);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            irq_in  = ($urandom_range(0, 3) == 0);
            irq_id  = 2'($urandom_range(0, 3));
            int_en  = ($urandom_range(0, 7) != 0);
            int_ack = ($urandom_range(0, 2) == 0);
            int_eoi = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; irq_in = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        idle(3);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("clr_q_drained", 32'(clr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
